// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the store-buffer memory controller: FSM state
// encoding and the default geometry used by the controller and its storage.
package mem_ctrl_pkg;

    localparam int DEF_DEPTH      = 4;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_REQ  = 2'd1,
        LD_RESP = 2'd2,
        ST_REQ  = 2'd3
    } sb_state_e;

endpackage

// File: rtl/sb_entries.sv
// Circular store-buffer storage: head/tail pointers, occupancy count, per-entry
// valid bits and a full-width address match across all valid entries.
module sb_entries
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [ADDR_W-1:0]        head_addr,
    output logic [DATA_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [ADDR_W-1:0]        match_addr,
    output logic                     match
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [PTR_W:0]    count_reg;
    logic [DEPTH-1:0]  hit_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Payload needs no reset: an entry is only observable while its valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= push_addr;
            data_mem[tail_reg] <= push_data;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic valid_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_reg <= 1'b0;
            end else if (push && (tail_reg == PTR_W'(gi))) begin
                valid_reg <= 1'b1;
            end else if (pop && (head_reg == PTR_W'(gi))) begin
                valid_reg <= 1'b0;
            end
        end

        assign hit_vec[gi] = valid_reg && (addr_mem[gi] == match_addr);
    end

    assign match     = |hit_vec;
    assign head_addr = addr_mem[head_reg];
    assign head_data = data_mem[head_reg];
    assign count     = count_reg;

endmodule

// File: rtl/store_buffer_ctrl.sv
// Store buffer controller: queues CPU stores, arbitrates buffered drains
// against CPU loads to a single memory port, and implements fence/flush.
module store_buffer_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_rvalid,
    output logic [DATA_W-1:0]        ld_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     flush_req,
    output logic                     flush_done,
    output logic [$clog2(DEPTH):0]   sb_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    sb_state_e         state_reg, state_next;
    logic              flushing_reg, flushing_next;
    logic [STV_W-1:0]  starve_reg, starve_next;
    logic [ADDR_W-1:0] ld_addr_reg;

    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              hazard;
    logic              push, pop, full, nonempty;
    logic              idle, drain_forced, load_sel, drain_sel;

    sb_entries #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_entries (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (st_addr),
        .push_data  (st_data),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (count),
        .match_addr (ld_addr),
        .match      (hazard)
    );

    assign full     = (count == CNT_W'(DEPTH));
    assign nonempty = (count != '0);
    assign st_ready = rst && !full && !flushing_reg;
    assign push     = st_valid && st_ready;
    assign pop      = (state_reg == ST_REQ) && mem_gnt;

    // Gating with rst keeps the combinational handshakes quiet while reset is held.
    assign idle         = rst && (state_reg == IDLE);
    assign drain_forced = nonempty &&
                          (flushing_reg || full || (starve_reg == STV_W'(STARVE_MAX)));
    assign load_sel     = idle && !drain_forced && ld_valid && !flushing_reg && !hazard;
    assign drain_sel    = idle && nonempty && !load_sel;
    assign flush_done   = idle && flushing_reg && !nonempty;
    assign ld_ready     = load_sel;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (load_sel)       state_next = LD_REQ;
                else if (drain_sel) state_next = ST_REQ;
            end
            LD_REQ:  if (mem_gnt)    state_next = LD_RESP;
            LD_RESP: if (mem_rvalid) state_next = IDLE;
            ST_REQ:  if (mem_gnt)    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        starve_next = starve_reg;
        if (drain_sel || (idle && !nonempty)) begin
            starve_next = '0;
        end else if (load_sel && nonempty && (starve_reg < STV_W'(STARVE_MAX))) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    // A new fence request wins over completion of the current one.
    assign flushing_next = flush_req ? 1'b1 : (flush_done ? 1'b0 : flushing_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            flushing_reg <= 1'b0;
            starve_reg   <= '0;
            ld_addr_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            flushing_reg <= flushing_next;
            starve_reg   <= starve_next;
            if (load_sel) ld_addr_reg <= ld_addr;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_reg)
            LD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = ld_addr_reg;
            end
            ST_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_addr;
                mem_wdata = head_data;
            end
            default: ;
        endcase
    end

    assign ld_rvalid = (state_reg == LD_RESP) && mem_rvalid;
    assign ld_rdata  = ld_rvalid ? mem_rdata : '0;
    assign sb_count  = count;

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Randomized bench for store_buffer_ctrl: a queue-based reference model of the
// buffer and the single outstanding memory transaction predicts every output.
module tb_store_buffer_ctrl;

    localparam int DEPTH      = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 8;

    localparam int T_NONE      = 0;
    localparam int T_LOAD_ADDR = 1;
    localparam int T_LOAD_DATA = 2;
    localparam int T_WRITE     = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } store_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   st_valid, st_ready;
    logic [ADDR_W-1:0]      st_addr;
    logic [DATA_W-1:0]      st_data;
    logic                   ld_valid, ld_ready;
    logic [ADDR_W-1:0]      ld_addr;
    logic                   ld_rvalid;
    logic [DATA_W-1:0]      ld_rdata;
    logic                   mem_req, mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   mem_gnt, mem_rvalid;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   flush_req, flush_done;
    logic [$clog2(DEPTH):0] sb_count;

    int n_cmp = 0;
    int n_bad = 0;

    store_t            m_q[$];
    int                m_txn;
    int                m_starve;
    bit                m_flushing;
    logic [ADDR_W-1:0] m_ld_addr;

    always #5 clk = ~clk;

    store_buffer_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_rvalid  (ld_rvalid),
        .ld_rdata   (ld_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .sb_count   (sb_count)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: evaluated mid-cycle, it predicts this cycle's outputs
    // and then advances to the state that holds after the coming rising edge.
    always @(negedge clk) begin
        int n;
        bit hz, idle, forced, sel_ld, sel_dr, exp_str, exp_fd, push, pop;
        logic [65:0] exp_bus;
        logic [32:0] exp_resp;

        if (!rst) begin
            m_q.delete();
            m_txn      = T_NONE;
            m_starve   = 0;
            m_flushing = 1'b0;
            check_eq("reset_outputs",
                     {st_ready, ld_ready, ld_rvalid, ld_rdata, mem_req, mem_we,
                      mem_addr, mem_wdata, flush_done, sb_count}, '0);
        end else begin
            n  = m_q.size();
            hz = 1'b0;
            foreach (m_q[i]) if (m_q[i].addr == ld_addr) hz = 1'b1;

            idle    = (m_txn == T_NONE);
            forced  = (n > 0) && (m_flushing || n == DEPTH || m_starve == STARVE_MAX);
            sel_ld  = idle && !forced && ld_valid && !m_flushing && !hz;
            sel_dr  = idle && (n > 0) && !sel_ld;
            exp_str = (n < DEPTH) && !m_flushing;
            exp_fd  = idle && m_flushing && (n == 0);

            exp_bus = '0;
            if (m_txn == T_LOAD_ADDR) exp_bus = {1'b1, 1'b0, m_ld_addr, 32'h0};
            if (m_txn == T_WRITE)     exp_bus = {1'b1, 1'b1, m_q[0].addr, m_q[0].data};
            exp_resp = (m_txn == T_LOAD_DATA && mem_rvalid) ? {1'b1, mem_rdata} : 33'h0;

            check_eq("st_ready",   st_ready, exp_str);
            check_eq("sb_count",   sb_count, n);
            check_eq("ld_ready",   ld_ready, sel_ld);
            check_eq("mem_bus",    {mem_req, mem_we, mem_addr, mem_wdata}, exp_bus);
            check_eq("ld_resp",    {ld_rvalid, ld_rdata}, exp_resp);
            check_eq("flush_done", flush_done, exp_fd);

            if (m_txn == T_WRITE && mem_gnt)
                $display("[%0t] write addr=%h data=%h", $time, m_q[0].addr, m_q[0].data);
            if (exp_resp[32])
                $display("[%0t] load  addr=%h data=%h", $time, m_ld_addr, mem_rdata);
            if (exp_fd)
                $display("[%0t] flush complete", $time);

            push = st_valid && exp_str;
            pop  = (m_txn == T_WRITE) && mem_gnt;

            if (sel_dr) m_starve = 0;
            else if (sel_ld && n > 0 && m_starve < STARVE_MAX) m_starve++;

            if (flush_req)   m_flushing = 1'b1;
            else if (exp_fd) m_flushing = 1'b0;

            case (m_txn)
                T_NONE:      m_txn = sel_ld ? T_LOAD_ADDR : (sel_dr ? T_WRITE : T_NONE);
                T_LOAD_ADDR: if (mem_gnt)    m_txn = T_LOAD_DATA;
                T_LOAD_DATA: if (mem_rvalid) m_txn = T_NONE;
                default:     if (mem_gnt)    m_txn = T_NONE;
            endcase

            if (sel_ld) m_ld_addr = ld_addr;
            if (pop)    void'(m_q.pop_front());
            if (push)   m_q.push_back('{addr: st_addr, data: st_data});
        end
    end

    // One randomized stimulus phase; probabilities are percentages.
    task automatic run_phase(input int cycles, input int p_st, input int p_ld, input int p_gnt,
                             input int p_rv, input int p_fl, input bit far_loads);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            st_valid   = ($urandom_range(99) < p_st);
            st_addr    = 32'h100 + ($urandom_range(3) << 2);
            st_data    = $urandom;
            ld_valid   = ($urandom_range(99) < p_ld);
            ld_addr    = far_loads ? 32'h1000 + ($urandom_range(15) << 2)
                                   : 32'h100 + ($urandom_range(3) << 2);
            mem_gnt    = ($urandom_range(99) < p_gnt);
            mem_rvalid = ($urandom_range(99) < p_rv);
            mem_rdata  = $urandom;
            flush_req  = ($urandom_range(99) < p_fl);
        end
    endtask

    initial begin
        rst        = 1'b0;
        st_valid   = 1'b0;
        st_addr    = '0;
        st_data    = '0;
        ld_valid   = 1'b0;
        ld_addr    = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        flush_req  = 1'b0;

        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        run_phase(40,   100, 0,   100, 0,   0, 1'b0);  // back-to-back stores, grant tied high
        run_phase(300,  50,  60,  40,  50,  0, 1'b0);  // loads colliding with buffered stores
        run_phase(4,    100, 0,   0,   0,   0, 1'b0);
        run_phase(200,  10,  100, 100, 100, 0, 1'b1);  // loads continuously winning arbitration
        run_phase(300,  70,  40,  50,  60,  5, 1'b0);  // fences with stores held
        run_phase(1000, 60,  30,  30,  50,  2, 1'b0);  // full buffer, pointer wrap
        run_phase(20,   100, 0,   0,   0,   0, 1'b0);  // stall a drain

        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_mem_req",  mem_req, 1'b0);
        check_eq("rst_sb_count", sb_count, '0);
        run_phase(2, 100, 100, 100, 100, 0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;

        run_phase(40,  0,  0,  100, 100, 0, 1'b0);  // nothing may be written after reset
        run_phase(200, 50, 40, 50,  50,  3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
